modo1_detector_nota: RTL

//  Player-side front end for mode 1. Debounces the piano keys while it is the player's turn and encodes
//  the pressed key into a note index. Measures how long the key is held in metronome ticks. On release
//  it issues a one-cycle nota_feita pulse, with nota_correta and tempo_correto stable for the mode-1

---
 rtl/modo1_detector_nota.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/modo1_detector_nota.sv
// -----------------------------------------------------------------------------
// modo1_detector_nota
// Player-side front end for mode 1. While it is the player's turn it debounces
// the piano keys, encodes the pressed key into a note index, measures the hold
// time in metronome ticks and, on a debounced release, raises nota_feita for
// one cycle with nota_correta / tempo_correto already registered.
//
// Ports
//   clock            in   rising-edge system clock
//   reset            in   asynchronous, active-low
//   habilita         in   player turn; low forces aguarda_livre, keys ignored
//   teclas           in   raw key levels, 1 = pressed
//   tick_metro       in   one-cycle metronome subdivision pulse
//   nota_esperada    in   expected note index (sampled on entry to finaliza)
//   duracao_esperada in   expected hold time in ticks (sampled on entry to finaliza)
//   nota_feita       out  one-cycle pulse: a press/release was captured
//   nota             out  index of the captured key (lowest pressed index)
//   duracao          out  captured hold time in ticks (saturating)
//   nota_correta     out  single key and nota == nota_esperada
//   tempo_correto    out  |duracao - duracao_esperada| <= TOLERANCIA
//   db_estado        out  current FSM state code
// -----------------------------------------------------------------------------
module modo1_detector_nota #(
    parameter int NUM_TECLAS      = 12,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int LARGURA_DUR     = 8,
    parameter int TOLERANCIA      = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic [NUM_TECLAS-1:0]  teclas,
    input  logic                   tick_metro,
    input  logic [3:0]             nota_esperada,
    input  logic [LARGURA_DUR-1:0] duracao_esperada,
    output logic                   nota_feita,
    output logic [3:0]             nota,
    output logic [LARGURA_DUR-1:0] duracao,
    output logic                   nota_correta,
    output logic                   tempo_correto,
    output logic [2:0]             db_estado
);

    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0]          CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [LARGURA_DUR-1:0] DUR_MAX = '1;
    localparam logic [LARGURA_DUR:0]   TOL     = (LARGURA_DUR + 1)'(TOLERANCIA);

    typedef enum logic [2:0] {
        AGUARDA_LIVRE  = 3'd0,
        OCIOSO         = 3'd1,
        DEBOUNCE_PRESS = 3'd2,
        PRESSIONADA    = 3'd3,
        DEBOUNCE_SOLTA = 3'd4,
        FINALIZA       = 3'd5
    } estado_t;

    estado_t                estado_q,   estado_d;
    logic [NUM_TECLAS-1:0]  vetor_q,    vetor_d;
    logic [CW-1:0]          cnt_q,      cnt_d;
    logic [3:0]             nota_q,     nota_d;
    logic                   multipla_q, multipla_d;
    logic [LARGURA_DUR-1:0] duracao_q,  duracao_d;
    logic                   correta_q,  correta_d;
    logic                   tempo_q,    tempo_d;

    // Key encoder: lowest pressed index wins; multiple keys flagged separately.
    logic [3:0] indice;
    logic       varias;

    always_comb begin
        indice = '0;
        for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
            if (teclas[i]) indice = 4'(i);
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign varias = |(teclas & (teclas - NUM_TECLAS'(1)));

    // Saturating tick counter value for this cycle.
    logic [LARGURA_DUR-1:0] dur_inc;
    assign dur_inc = (tick_metro && (duracao_q != DUR_MAX)) ? duracao_q + LARGURA_DUR'(1)
                                                             : duracao_q;

    // Duration compare in one extra bit, signed, so the difference never wraps.
    // Uses dur_inc so a tick in the last debounce_solta cycle is included.
    logic signed [LARGURA_DUR:0] diff;
    logic        [LARGURA_DUR:0] abs_diff;
    logic                        tempo_ok;

    assign diff     = $signed({1'b0, dur_inc}) - $signed({1'b0, duracao_esperada});
    assign abs_diff = diff[LARGURA_DUR] ? (-diff) : diff;
    assign tempo_ok = (abs_diff <= TOL);

    always_comb begin
        estado_d   = estado_q;
        vetor_d    = vetor_q;
        cnt_d      = cnt_q;
        nota_d     = nota_q;
        multipla_d = multipla_q;
        duracao_d  = duracao_q;
        correta_d  = correta_q;
        tempo_d    = tempo_q;

        if (!habilita) begin
            // Leaving the turn abandons any press; captured outputs are kept.
            estado_d = AGUARDA_LIVRE;
        end else begin
            unique case (estado_q)
                AGUARDA_LIVRE: begin
                    // A key already down when the turn starts must be released first.
                    if (teclas == '0) estado_d = OCIOSO;
                end
                OCIOSO: begin
                    if (teclas != '0) begin
                        estado_d = DEBOUNCE_PRESS;
                        vetor_d  = teclas;
                        cnt_d    = '0;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (teclas != vetor_q) begin
                        estado_d = OCIOSO;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_d   = PRESSIONADA;
                        nota_d     = indice;
                        multipla_d = varias;
                        duracao_d  = '0;  // a tick in this cycle is deliberately dropped
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSIONADA: begin
                    duracao_d = dur_inc;
                    if (teclas == '0) begin
                        estado_d = DEBOUNCE_SOLTA;
                        cnt_d    = '0;
                    end
                end
                DEBOUNCE_SOLTA: begin
                    duracao_d = dur_inc;
                    if (teclas != '0) begin
                        // Release bounce: resume the same press, duration kept.
                        estado_d = PRESSIONADA;
                    end else if (cnt_q == CNT_MAX) begin
                        estado_d  = FINALIZA;
                        correta_d = !multipla_q && (nota_q == nota_esperada);
                        tempo_d   = tempo_ok;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                FINALIZA: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = AGUARDA_LIVRE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= AGUARDA_LIVRE;
            vetor_q    <= '0;
            cnt_q      <= '0;
            nota_q     <= '0;
            multipla_q <= 1'b0;
            duracao_q  <= '0;
            correta_q  <= 1'b0;
            tempo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            vetor_q    <= vetor_d;
            cnt_q      <= cnt_d;
            nota_q     <= nota_d;
            multipla_q <= multipla_d;
            duracao_q  <= duracao_d;
            correta_q  <= correta_d;
            tempo_q    <= tempo_d;
        end
    end

    // Gated by habilita so a turn ending during finaliza produces no pulse.
    assign nota_feita    = (estado_q == FINALIZA) && habilita;
    assign nota          = nota_q;
    assign duracao       = duracao_q;
    assign nota_correta  = correta_q;
    assign tempo_correto = tempo_q;
    assign db_estado     = estado_q;

endmodule
